// File: rtl/rgb_to_gray.sv
// rtl/rgb_to_gray.sv - RGB565 byte-pair receiver converting each pixel to 8-bit luma
// Reassembles lo/hi bytes into a pixel, registers its gray value with a frame-last flag.
module rgb_to_gray #(
  parameter int GRAY_PXL_W  = 8,
  parameter int RGB_PXL_W   = 16,
  parameter int RGB_SPLIT_W = 8,
  parameter int FRAME_PXL   = 76800,
  parameter int PXL_CNT_W   = 17
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RGB_SPLIT_W-1:0] rgb_pxl_dat_i,
  input  logic                   rgb_pxl_vld_i,
  output logic                   rgb_pxl_rdy_o,
  input  logic                   sync_clr_i,
  output logic [GRAY_PXL_W-1:0]  gray_pxl_dat_o,
  output logic                   gray_pxl_vld_o,
  output logic                   gray_pxl_last_o,
  input  logic                   gray_pxl_rdy_i,
  output logic [PXL_CNT_W-1:0]   pxl_cnt_o
);

  typedef enum logic {WAIT_LO = 1'b0, WAIT_HI = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [RGB_SPLIT_W-1:0] r_lo_byte;
  logic [GRAY_PXL_W-1:0]  r_gray_dat;
  logic                   r_gray_vld;
  logic                   r_gray_last;
  logic [PXL_CNT_W-1:0]   r_pxl_cnt;

  logic                   w_rdy;
  logic                   w_in_hsk;
  logic                   w_out_hsk;
  logic                   w_load;
  logic                   w_cnt_last;
  logic [RGB_PXL_W-1:0]   w_pix;
  logic [7:0]             w_r8;
  logic [7:0]             w_g8;
  logic [7:0]             w_b8;
  logic [15:0]            w_sum;

  assign w_in_hsk   = rgb_pxl_vld_i & w_rdy;
  assign w_out_hsk  = r_gray_vld & gray_pxl_rdy_i;
  assign w_load     = w_in_hsk & (r_state == WAIT_HI) & ~sync_clr_i;
  assign w_cnt_last = (r_pxl_cnt == PXL_CNT_W'(FRAME_PXL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_LO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (sync_clr_i) begin
      w_state_nxt = WAIT_LO;
    end else if (w_in_hsk) begin
      w_state_nxt = (r_state == WAIT_LO) ? WAIT_HI : WAIT_LO;
    end
  end

  // The high byte may only be taken when the output register can accept a new pixel.
  always_comb begin
    w_rdy = 1'b1;
    if (r_state == WAIT_HI) begin
      w_rdy = ~r_gray_vld | gray_pxl_rdy_i;
    end
  end

  assign w_pix = {rgb_pxl_dat_i, r_lo_byte};
  assign w_r8  = {w_pix[15:11], w_pix[15:13]};
  assign w_g8  = {w_pix[10:5],  w_pix[10:9]};
  assign w_b8  = {w_pix[4:0],   w_pix[4:2]};
  assign w_sum = 16'd77 * 16'(w_r8) + 16'd150 * 16'(w_g8) + 16'd29 * 16'(w_b8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo_byte <= '0;
    end else if (w_in_hsk && (r_state == WAIT_LO) && !sync_clr_i) begin
      r_lo_byte <= rgb_pxl_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gray_dat  <= '0;
      r_gray_vld  <= 1'b0;
      r_gray_last <= 1'b0;
    end else if (w_load) begin
      r_gray_dat  <= w_sum[15:8];
      r_gray_vld  <= 1'b1;
      r_gray_last <= w_cnt_last;
    end else if (w_out_hsk) begin
      r_gray_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pxl_cnt <= '0;
    end else if (sync_clr_i) begin
      r_pxl_cnt <= '0;
    end else if (w_load) begin
      r_pxl_cnt <= w_cnt_last ? '0 : r_pxl_cnt + 1'b1;
    end
  end

  assign rgb_pxl_rdy_o   = w_rdy;
  assign gray_pxl_dat_o  = r_gray_dat;
  assign gray_pxl_vld_o  = r_gray_vld;
  assign gray_pxl_last_o = r_gray_last;
  assign pxl_cnt_o       = r_pxl_cnt;

endmodule
